// File: rtl/pmem_arbiter.sv
// Round-robin arbiter that shares one 64-bit physical memory port between the
// I-cache (fills) and D-cache (fills/writebacks), one 4-beat line burst at a time.
module pmem_arbiter #(
  parameter int BEATS  = 4,
  parameter int BEAT_W = 64,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [31:0]       d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [31:0] LINE_MASK = 32'(LINE_W / 8 - 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  beat, beat_inc;
  logic              last_beat;
  logic              last_d, gnt_d, is_write;
  logic              i_req, d_req, grant_d;
  logic [31:0]       req_address;
  logic [LINE_W-1:0] line_q, line_fill;

  assign i_req       = i_read;
  assign d_req       = d_read | d_write;
  // On a tie the side that did not win last time gets the port.
  assign grant_d     = d_req && (!i_req || !last_d);
  assign req_address = grant_d ? d_address : i_address;
  assign beat_inc    = beat + 1'b1;
  assign last_beat   = (beat == CNT_W'(BEATS - 1));

  always_comb begin
    line_fill = line_q;
    line_fill[int'(beat) * BEAT_W +: BEAT_W] = pmem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (i_req || d_req) state_next = BURST;
      BURST:   if (pmem_resp && last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The response pulse is registered on the BURST->DONE edge so it is high
  // exactly during the DONE cycle, together with the final line data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat         <= '0;
      last_d       <= 1'b1;
      gnt_d        <= 1'b0;
      is_write     <= 1'b0;
      line_q       <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
      pmem_address <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_wdata   <= '0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_req || d_req) begin
            gnt_d        <= grant_d;
            last_d       <= grant_d;
            is_write     <= grant_d && d_write;
            beat         <= '0;
            pmem_address <= req_address & ~LINE_MASK;
            pmem_read    <= !(grant_d && d_write);
            pmem_write   <= grant_d && d_write;
            pmem_wdata   <= d_wdata[BEAT_W-1:0];
            if (grant_d && d_write) line_q <= d_wdata;
          end
        end
        BURST: begin
          if (pmem_resp) begin
            beat       <= beat_inc;
            pmem_wdata <= line_q[int'(beat_inc) * BEAT_W +: BEAT_W];
            if (!is_write) line_q <= line_fill;
            if (last_beat) begin
              pmem_read  <= 1'b0;
              pmem_write <= 1'b0;
              if (gnt_d) d_resp <= 1'b1;
              else       i_resp <= 1'b1;
              if (!is_write) begin
                if (gnt_d) d_rdata <= line_fill;
                else       i_rdata <= line_fill;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level model of arbitration and bursts.
module tb_pmem_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_address, d_address, pmem_address;
  logic         i_read, i_resp, d_read, d_write, d_resp;
  logic [255:0] i_rdata, d_rdata, d_wdata;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [63:0]  pmem_wdata, pmem_rdata;

  int cmp_count = 0;
  int err_count = 0;

  // Model of the requesters and of what each side should currently hold.
  bit           i_pend, d_pend, d_rd_m, d_wr_m, last_d;
  logic [31:0]  i_addr_m, d_addr_m;
  logic [255:0] d_wline_m, i_line_m, d_line_m;
  logic [63:0]  beat_data [4];
  bit           use_fixed;

  always #5 clk = ~clk;

  pmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    cmp_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_requests();
    i_read    = i_pend;
    i_address = i_addr_m;
    d_read    = d_pend & d_rd_m;
    d_write   = d_pend & d_wr_m;
    d_address = d_addr_m;
    d_wdata   = d_wline_m;
  endtask

  // side 0 = I, side 1 = D
  task automatic applyStimulus(input bit side, input logic [31:0] addr, input bit rd,
                               input bit wr, input logic [255:0] wdata);
    if (!side) begin
      i_pend = 1'b1; i_addr_m = addr;
    end else begin
      d_pend = 1'b1; d_addr_m = addr; d_rd_m = rd; d_wr_m = wr; d_wline_m = wdata;
    end
    drive_requests();
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_ctl"}, 256'({pmem_address, pmem_read, pmem_write, pmem_wdata, i_resp, d_resp}), '0);
    checkOutput({tag, "_irdata"}, i_rdata, '0);
    checkOutput({tag, "_drdata"}, d_rdata, '0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0;
    drive_requests();
    pmem_resp = 1'b0;
    i_line_m = '0; d_line_m = '0; last_d = 1'b1;
    step(); step();
    check_all_zero("reset");
    rst = 1'b1;
    step();
  endtask

  // Serves one complete burst as the memory, then checks the response cycle.
  // wait_mode < 0 inserts 0..3 random idle cycles before each beat.
  task automatic run_transfer(input int wait_mode, input int exp_lat, output bit gd);
    bit wr;
    int n, w;
    logic [31:0]  ea;
    logic [255:0] line;
    logic [63:0]  b;
    gd   = d_pend && (!i_pend || !last_d);
    wr   = gd && d_wr_m;
    ea   = (gd ? d_addr_m : i_addr_m) & 32'hFFFF_FFE0;
    line = '0;
    n = 0;
    while (!(pmem_read || pmem_write) && n < 10) begin
      step();
      n++;
    end
    checkOutput("strobe_seen", 256'(n < 10), 256'(1));
    if (n >= 10) return;
    if (exp_lat >= 0) checkOutput("grant_latency", 256'(n), 256'(exp_lat));
    checkOutput("burst_addr", 256'(pmem_address), 256'(ea));
    for (int k = 0; k < 4; k++) begin
      w = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
      for (int j = 0; j < w; j++) begin
        pmem_resp  = 1'b0;
        pmem_rdata = {$urandom, $urandom};
        step();
        checkOutput("strobe_wait", 256'({pmem_read, pmem_write}), 256'({!wr, wr}));
      end
      b = use_fixed ? beat_data[k] : {$urandom, $urandom};
      pmem_resp  = 1'b1;
      pmem_rdata = b;
      checkOutput("strobe_beat", 256'({pmem_read, pmem_write}), 256'({!wr, wr}));
      checkOutput("addr_hold", 256'(pmem_address), 256'(ea));
      if (wr) checkOutput("wdata_beat", 256'(pmem_wdata), 256'(d_wline_m[k*64 +: 64]));
      line[k*64 +: 64] = b;
      step();
    end
    pmem_resp = 1'b0;
    checkOutput("strobe_off", 256'({pmem_read, pmem_write}), '0);
    checkOutput("resp_sides", 256'({i_resp, d_resp}), 256'({!gd, gd}));
    if (!wr) begin
      if (gd) d_line_m = line;
      else    i_line_m = line;
    end
    checkOutput("i_rdata", i_rdata, i_line_m);
    checkOutput("d_rdata", d_rdata, d_line_m);
    last_d = gd;
    if (gd) d_pend = 1'b0;
    else    i_pend = 1'b0;
    drive_requests();
    step();
    checkOutput("resp_pulse_end", 256'({i_resp, d_resp}), '0);
  endtask

  initial begin
    bit gd;
    int r;
    rst = 1'b0; pmem_resp = 1'b0; pmem_rdata = '0;
    i_pend = 0; d_pend = 0; d_rd_m = 0; d_wr_m = 0;
    i_addr_m = '0; d_addr_m = '0; d_wline_m = '0;
    use_fixed = 1'b1;
    drive_requests();
    do_reset();

    // I fill alone with known beats, back-to-back
    beat_data[0] = {16{4'h1}}; beat_data[1] = {16{4'h2}};
    beat_data[2] = {16{4'h3}}; beat_data[3] = {16{4'h4}};
    applyStimulus(0, 32'h0000_1234, 1, 0, '0);
    run_transfer(0, 1, gd);
    checkOutput("t1_line", i_rdata, {beat_data[3], beat_data[2], beat_data[1], beat_data[0]});

    // D writeback
    applyStimulus(1, 32'h8000_0040, 0, 1, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}});
    run_transfer(0, 1, gd);

    // Simultaneous requests after reset, then continuous contention
    do_reset();
    applyStimulus(0, 32'h0000_2000, 1, 0, '0);
    applyStimulus(1, 32'h0000_3000, 1, 0, '0);
    for (int t = 0; t < 6; t++) begin
      beat_data[0] = {$urandom, $urandom}; beat_data[1] = {$urandom, $urandom};
      beat_data[2] = {$urandom, $urandom}; beat_data[3] = {$urandom, $urandom};
      run_transfer(0, 1, gd);
      checkOutput("rr_order", 256'(gd), 256'(t % 2));
      if (gd) applyStimulus(1, 32'h0000_3000 + 32'(t) * 32'h20, 1, 0, '0);
      else    applyStimulus(0, 32'h0000_2000 + 32'(t) * 32'h20, 1, 0, '0);
    end
    do_reset();

    // D fill with three idle cycles before every beat
    use_fixed = 1'b0;
    applyStimulus(1, 32'h0000_5A5F, 1, 0, '0);
    run_transfer(3, 1, gd);

    // Reset in the middle of an I fill
    applyStimulus(0, 32'h0000_7700, 1, 0, '0);
    step();
    pmem_resp = 1'b1; pmem_rdata = 64'hDEAD_BEEF_0000_0001; step();
    pmem_rdata = 64'hDEAD_BEEF_0000_0002; step();
    pmem_resp = 1'b0;
    #2 rst = 1'b0;
    #1 check_all_zero("async_reset");
    i_pend = 1'b0; d_pend = 1'b0; drive_requests();
    i_line_m = '0; d_line_m = '0; last_d = 1'b1;
    step();
    rst = 1'b1;
    step();
    applyStimulus(0, 32'h0000_7700, 1, 0, '0);
    run_transfer(0, 1, gd);

    // Illegal read+write on D is a write
    applyStimulus(1, 32'h0000_9920, 1, 1, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    run_transfer(-1, 1, gd);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      if (!i_pend && $urandom_range(0, 1) == 1)
        applyStimulus(0, $urandom, 1, 0, '0);
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        r = int'($urandom_range(0, 5));
        applyStimulus(1, $urandom, r != 3 && r != 4, r >= 3,
                      {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      end
      if (!i_pend && !d_pend) applyStimulus(0, $urandom, 1, 0, '0);
      run_transfer(-1, -1, gd);
    end
    while (i_pend || d_pend) run_transfer(-1, -1, gd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end
endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Sits between the split instruction/data cache pair and the single 64-bit physical memory port.
- Turns one 256-bit cache-line fill or writeback into a 4-beat burst on pmem.
- Shares the pmem port between the I-side requester (read only) and the D-side requester (read or write) using round-robin arbitration.
- Returns each completed line to its requester with a one-cycle response pulse.

Parameters:
- BEATS, 4, beats per line burst; fixed at 4 in this revision.
- BEAT_W, 64, pmem data width in bits.
- LINE_W, 256, cache line width in bits; must equal BEATS*BEAT_W.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = in reset).
- i_address  input  32  I-side line address.
- i_read  input  1  I-side line fill request (level).
- i_rdata  output  256  I-side fill data.
- i_resp  output  1  I-side completion pulse.
- d_address  input  32  D-side line address.
- d_read  input  1  D-side fill request (level).
- d_write  input  1  D-side writeback request (level).
- d_wdata  input  256  D-side writeback line.
- d_rdata  output  256  D-side fill data.
- d_resp  output  1  D-side completion pulse.
- pmem_address  output  32  burst base address; bits [4:0] always 0.
- pmem_read  output  1  burst read strobe.
- pmem_write  output  1  burst write strobe.
- pmem_wdata  output  64  current write beat.
- pmem_rdata  input  64  current read beat.
- pmem_resp  input  1  beat accepted/valid.

Behaviour:
- Reset (rst=0, any time including mid-burst):
  - State goes to IDLE, beat counter = 0, last_grant = D (so I wins the first tie).
  - All outputs are 0, including i_rdata and d_rdata.
  - The pmem model is reset in the same event.
- All pmem-side outputs and i_resp/d_resp are registered.
- Requests are level signals held stable until the matching *_resp.
- d_read and d_write asserted together is illegal; d_write takes precedence.
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - Evaluate i_req = i_read and d_req = d_read|d_write.
  - One requester pending: grant it.
  - Both pending: grant the side not equal to last_grant.
  - On grant: latch the address with [4:0] forced to 0, latch direction, latch d_wdata if writing, clear the counter, update last_grant, go to BURST.
  - pmem_read/pmem_write rise on the cycle after the request is sampled.
- BURST:
  - pmem_read or pmem_write is held high continuously, with pmem_address constant.
  - pmem_wdata = latched line bits [64k+63:64k], where k = beat counter.
  - On each pmem_resp:
    - Read: capture pmem_rdata into line bits [64k+63:64k].
    - Increment k.
  - On the pmem_resp with k=3: deassert the strobe next cycle and go to DONE.
  - pmem_resp with no strobe active is ignored.
- DONE:
  - Pulse the granted side's *_resp for exactly one cycle.
  - For a read, the granted side's *_rdata holds the assembled line, valid from the resp cycle until that side's next grant completes.
  - Writebacks leave d_rdata unchanged.
  - Return to IDLE.
  - The requester drops its request in the cycle after resp. The arbiter ignores requests during DONE, so no double grant occurs.
- Minimum latency: request sampled at cycle t, strobe at t+1, four back-to-back beats t+1..t+4, *_resp at t+5. Back-to-back requests from the other side start at t+7.
- Wait states: any number of idle cycles between beats is tolerated; the counter only advances on pmem_resp.
- Fairness: under continuous contention, grants alternate I, D, I, D. No starvation beyond one line transfer.

Test Plan:
- I fill alone at 0x0000_1234, pmem returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles -> pmem_address=0x0000_1220, pmem_read high 4 cycles, i_resp at t+5, i_rdata = {0x44..,0x33..,0x22..,0x11..}.
- D writeback at 0x8000_0040, d_wdata = {beat3..beat0} with 0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD.. -> pmem_write high, pmem_wdata sequence A,B,C,D, d_resp pulse, d_rdata unchanged.
- i_read and d_read raised same cycle after reset -> I served first, then D. Repeating both continuously -> alternates I,D,I,D over 6 transfers.
- D fill with 3 idle cycles before each pmem_resp -> strobe held throughout, line assembled correctly, d_resp 1 cycle after 4th beat.
- rst pulled low after beat 2 of an I fill -> all outputs 0 asynchronously. After release, a fresh i_read re-runs the full 4-beat burst from beat 0.
- d_read=d_write=1 simultaneously -> treated as a write; pmem_read never asserted.
